// File: rtl/debug_pkg.sv
// Shared definitions for the debug byte-link controllers: command bytes,
// controller state encoding and the default link byte width.
package debug_pkg;

    localparam int DBG_NB_BYTE = 8;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_DUMP = 8'h04;
    localparam logic [7:0] CMD_STOP = 8'h05;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_H,
        ST_CNT_L,
        ST_LD_DATA,
        ST_RUN,
        ST_STEP,
        ST_DP_READ,
        ST_DP_WAIT,
        ST_DP_SEND
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Loads one memory word and emits it least-significant byte first over a
// valid/ready byte handshake. o_done marks the cycle the last byte transfers.
module word_serializer
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_done
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int IDX_W   = $clog2(N_BYTES);

    logic [NB_DATA-1:0] sh_p0;
    logic [IDX_W-1:0]   idx_p0;
    logic               vld_p0;
    logic               xfer;

    assign xfer       = vld_p0 & i_tx_ready;
    assign o_tx_data  = sh_p0[NB_BYTE-1:0];
    assign o_tx_valid = vld_p0;
    assign o_done     = xfer & (idx_p0 == IDX_W'(N_BYTES - 1));

    // Shift register: load a word, then drop one byte per accepted transfer.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sh_p0  <= '0;
            idx_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (i_load) begin
            sh_p0  <= i_word;
            idx_p0 <= '0;
            vld_p0 <= 1'b1;
        end else if (xfer) begin
            sh_p0  <= sh_p0 >> NB_BYTE;
            idx_p0 <= idx_p0 + IDX_W'(1);
            if (idx_p0 == IDX_W'(N_BYTES - 1)) begin
                vld_p0 <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instrmem_loader_ctrl.sv
// Host byte-link command decoder that owns the fetch stage debug port:
// loads and dumps instruction memory and runs or single-steps the pipeline.
module instrmem_loader_ctrl
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 16,
    parameter int NB_BYTE = DBG_NB_BYTE,
    parameter int N_ADDR  = 2048
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [NB_ADDR-1:0] o_instrmem_addr,
    output logic [NB_DATA-1:0] o_instrmem_data,
    output logic [3:0]         o_instrmem_we,
    output logic               o_instrmem_re,
    input  logic [NB_DATA-1:0] i_instrmem_data,
    input  logic               i_halt,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_error
);

    localparam int BPW   = NB_DATA / NB_BYTE;
    localparam int IDX_W = $clog2(BPW);

    state_t             state_q, state_d;
    logic               cmd_dump_q, cmd_dump_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NB_ADDR-1:0] k_q, k_d;
    logic [NB_DATA-1:0] asm_q, asm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;

    logic [7:0]         rx_byte;
    logic [15:0]        rx_count;
    logic               last_word;
    logic               ser_load;
    logic               ser_done;

    assign rx_byte   = 8'(i_rx_data);
    assign rx_count  = {cnt_q[15:8], rx_byte};
    // Word k is the last one when k + 1 reaches the count; no wrap at N_ADDR.
    assign last_word = (32'(k_q) + 32'd1) == 32'(cnt_q);

    assign o_instrmem_addr = k_q;
    assign o_instrmem_data = asm_q;
    assign o_instrmem_we   = {4{we_q}};
    assign o_instrmem_re   = (state_q == ST_DP_READ);
    assign o_valid         = valid_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_error         = error_q;

    word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (i_instrmem_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (ser_done)
    );

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            cmd_dump_q <= 1'b0;
            cnt_q      <= '0;
            k_q        <= '0;
            asm_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_dump_q <= cmd_dump_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            asm_q      <= asm_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Command decode, load/dump sequencing and run/step control.
    always_comb begin
        state_d    = state_q;
        cmd_dump_d = cmd_dump_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        asm_d      = asm_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        valid_d    = valid_q;
        error_d    = error_q;
        ser_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (rx_byte)
                        CMD_LOAD: begin
                            cmd_dump_d = 1'b0;
                            error_d    = 1'b0;
                            state_d    = ST_CNT_H;
                        end
                        CMD_DUMP: begin
                            cmd_dump_d = 1'b1;
                            error_d    = 1'b0;
                            state_d    = ST_CNT_H;
                        end
                        CMD_RUN: begin
                            error_d = 1'b0;
                            valid_d = 1'b1;
                            state_d = ST_RUN;
                        end
                        CMD_STEP: begin
                            error_d = 1'b0;
                            valid_d = 1'b1;
                            state_d = ST_STEP;
                        end
                        CMD_STOP: begin
                            error_d = 1'b0;
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_CNT_H: begin
                if (i_rx_valid) begin
                    cnt_d   = {rx_byte, cnt_q[7:0]};
                    state_d = ST_CNT_L;
                end
            end

            ST_CNT_L: begin
                if (i_rx_valid) begin
                    if (rx_count == 16'd0) begin
                        state_d = ST_IDLE;
                    end else if (32'(rx_count) > 32'(N_ADDR)) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = rx_count;
                        k_d     = '0;
                        asm_d   = '0;
                        idx_d   = '0;
                        state_d = cmd_dump_q ? ST_DP_READ : ST_LD_DATA;
                    end
                end
            end

            ST_LD_DATA: begin
                // The write cycle also accepts the first byte of the next word.
                if (we_q && last_word) begin
                    state_d = ST_IDLE;
                end else begin
                    if (we_q) begin
                        k_d = k_q + NB_ADDR'(1);
                    end
                    if (i_rx_valid) begin
                        asm_d = {i_rx_data, asm_q[NB_DATA-1:NB_BYTE]};
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(BPW - 1)) begin
                            we_d = 1'b1;
                        end
                    end
                end
            end

            ST_RUN: begin
                if (i_halt || (i_rx_valid && rx_byte == CMD_STOP)) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_STEP: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end

            ST_DP_READ: begin
                state_d = ST_DP_WAIT;
            end

            ST_DP_WAIT: begin
                ser_load = 1'b1;
                state_d  = ST_DP_SEND;
            end

            ST_DP_SEND: begin
                if (ser_done) begin
                    k_d     = k_q + NB_ADDR'(1);
                    state_d = last_word ? ST_IDLE : ST_DP_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instrmem_loader_ctrl.sv
// Directed bench for instrmem_loader_ctrl with a small instruction memory
// model and a tx byte collector.
module tb_instrmem_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata = '0;
    logic        halt = 1'b0;
    logic        valid;
    logic        busy;
    logic        error;

    int          n_assert = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          stab_err = 0;
    int          tx_mode = 0;
    int          cyc = 0;
    int          w0;
    int          nb;
    logic [7:0]  jit_pat = 8'b1011_0010;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [31:0] mem [0:2047];
    logic [7:0]  tx_q [$];
    logic [7:0]  exp_tx [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    always #5 clk = ~clk;

    instrmem_loader_ctrl dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_instrmem_addr (addr),
        .o_instrmem_data (wdata),
        .o_instrmem_we   (we),
        .o_instrmem_re   (re),
        .i_instrmem_data (rdata),
        .i_halt          (halt),
        .o_valid         (valid),
        .o_busy          (busy),
        .o_error         (error)
    );

    // Synchronous-read instruction memory, one cycle latency.
    always @(posedge clk) begin
        if (re) rdata <= mem[addr[10:0]];
    end

    // tx sink readiness: always ready, jittered, or stalled.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = jit_pat[cyc % 8];
            default: tx_ready = 1'b0;
        endcase
    end

    // Capture memory writes and accepted tx bytes; track tx data stability.
    always @(negedge clk) begin
        if (we == 4'hF) begin
            mem[addr[10:0]] = wdata;
            wr_cnt++;
        end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (prev_stall && tx_valid && (tx_data !== prev_data)) stab_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] ctl_vec();
        return {23'd0, we, re, tx_valid, valid, busy, error};
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_ctl", ctl_vec(), 32'd0);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_data", wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load two words
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("ld_we0", {28'd0, we}, 32'hF);
        chk("ld_addr0", {16'd0, addr}, 32'd0);
        chk("ld_data0", wdata, 32'h12345678);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("ld_we1", {28'd0, we}, 32'hF);
        chk("ld_addr1", {16'd0, addr}, 32'd1);
        chk("ld_data1", wdata, 32'hDEADBEEF);
        chk("ld_busy_wr", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ld_we_off", {28'd0, we}, 32'd0);
        chk("ld_idle", {31'd0, busy}, 32'd0);
        #1;
        chk("ld_wr_cnt", wr_cnt, 32'd2);

        // Dump with jittered tx_ready
        tx_mode = 1;
        tx_q.delete();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h02);
        wait_idle("dump_done", 300);
        #1;
        chk("dump_nbytes", tx_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < tx_q.size()) chk($sformatf("dump_byte%0d", i), {24'd0, tx_q[i]}, {24'd0, exp_tx[i]});
        end
        chk("dump_stable", stab_err, 32'd0);
        tx_mode = 0;

        // Dump throughput with tx_ready high: 6 cycles per word
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h02);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("dump_cycles", nb, 32'd12);

        // Run until halt; other bytes ignored
        send_byte(8'h02);
        chk("run_vld_on", {31'd0, valid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("run_vld_hold", {31'd0, valid}, 32'd1);
        send_byte(8'h7F);
        chk("run_drop_vld", {31'd0, valid}, 32'd1);
        chk("run_drop_err", {31'd0, error}, 32'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("run_halt_vld", {31'd0, valid}, 32'd0);
        chk("run_halt_idle", {31'd0, busy}, 32'd0);

        // Single step
        send_byte(8'h03);
        chk("step_vld_on", {31'd0, valid}, 32'd1);
        @(negedge clk);
        chk("step_vld_off", {31'd0, valid}, 32'd0);
        chk("step_idle", {31'd0, busy}, 32'd0);

        // Run then STOP
        send_byte(8'h02);
        chk("stop_vld_on", {31'd0, valid}, 32'd1);
        send_byte(8'h05);
        chk("stop_vld_off", {31'd0, valid}, 32'd0);
        chk("stop_idle", {31'd0, busy}, 32'd0);

        // Halt and STOP together
        send_byte(8'h02);
        @(negedge clk);
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        halt     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        halt     = 1'b0;
        chk("both_vld", {31'd0, valid}, 32'd0);
        chk("both_idle", {31'd0, busy}, 32'd0);
        chk("both_err", {31'd0, error}, 32'd0);

        // Unknown command, then cleared by STEP
        send_byte(8'h7F);
        chk("err_unknown", {31'd0, error}, 32'd1);
        chk("err_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h03);
        chk("err_clr_step", {31'd0, error}, 32'd0);
        @(negedge clk);

        // Count over the limit
        #1;
        w0 = wr_cnt;
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h01);
        chk("err_cnt", {31'd0, error}, 32'd1);
        chk("err_cnt_idle", {31'd0, busy}, 32'd0);
        #1;
        chk("err_cnt_nowr", wr_cnt, w0);
        send_byte(8'h03);
        chk("err_cnt_clr", {31'd0, error}, 32'd0);
        @(negedge clk);

        // Zero count
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        chk("n0_idle", {31'd0, busy}, 32'd0);
        chk("n0_err", {31'd0, error}, 32'd0);

        // Count of exactly N_ADDR accepted; reset during the stalled dump
        tx_mode = 2;
        send_byte(8'h04); send_byte(8'h08); send_byte(8'h00);
        repeat (4) @(negedge clk);
        chk("nmax_busy", {31'd0, busy}, 32'd1);
        chk("nmax_err", {31'd0, error}, 32'd0);
        chk("nmax_txv", {31'd0, tx_valid}, 32'd1);
        chk("nmax_txd", {24'd0, tx_data}, 32'h78);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dump_ctl", ctl_vec(), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        tx_mode = 0;

        // Reset mid-load after the 6th byte
        #1;
        w0 = wr_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        chk("rst_ld_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ld_ctl", ctl_vec(), 32'd0);
        chk("rst_ld_data", wdata, 32'd0);
        chk("rst_ld_nowr", wr_cnt, w0);
        chk("rst_ld_mem0", mem[0], 32'h12345678);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h03);
        chk("rst_ld_step", {31'd0, valid}, 32'd1);
        @(negedge clk);

        // Fresh load after reset assembles from a clean register
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("reld_we", {28'd0, we}, 32'hF);
        chk("reld_addr", {16'd0, addr}, 32'd0);
        chk("reld_data", wdata, 32'h44332211);
        @(negedge clk);
        chk("reld_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
